// File: rtl/modn_prog_counter.sv
// modn_prog_counter: programmable modulo-M up/down counter with deferred modulus update.
// Define MODN_SATURATE_EN to saturate at the terminal value instead of wrapping.
module modn_prog_counter #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] mod_active,
  output logic             mod_pending
);
  logic [WIDTH-1:0] count_q, count_d, mod_q, mod_d, pend_q, pend_d;
  logic             wrap_q, wrap_d, pending_q, pending_d, at_term, apply;
  logic [WIDTH:0]   m_last, m_last_n, load_x, load_clamp;
  function automatic logic [WIDTH:0] last_of(input logic [WIDTH-1:0] m);
    return (m == '0) ? {1'b0, {WIDTH{1'b1}}} : {1'b0, m} - 1'b1;
  endfunction
  always_comb begin
    m_last     = last_of(mod_q);
    at_term    = up ? ({1'b0, count_q} == m_last) : (count_q == '0);
    tc         = en & ~load & at_term;
`ifdef MODN_SATURATE_EN
    apply      = load & (pending_q | mod_wr);
`else
    apply      = (load | tc) & (pending_q | mod_wr);
`endif
    mod_d      = apply ? (mod_wr ? mod_in : pend_q) : mod_q;
    m_last_n   = last_of(mod_d);
    pend_d     = mod_wr ? mod_in : pend_q;
    pending_d  = ~apply & (mod_wr | pending_q);
    load_x     = {1'b0, load_val};
    load_clamp = (load_x > m_last_n) ? m_last_n : load_x;
`ifdef MODN_SATURATE_EN
    wrap_d     = 1'b0;
    count_d    = load ? load_clamp[WIDTH-1:0] : (~en | tc) ? count_q :
                 up ? count_q + 1'b1 : count_q - 1'b1;
`else
    wrap_d     = tc;
    count_d    = load ? load_clamp[WIDTH-1:0] : ~en ? count_q :
                 tc ? (up ? '0 : m_last_n[WIDTH-1:0]) :
                 up ? count_q + 1'b1 : count_q - 1'b1;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      mod_q     <= WIDTH'(DEFAULT_MOD);
      pend_q    <= '0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      mod_q     <= mod_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      wrap_q    <= wrap_d;
    end
  end
  assign count       = count_q;
  assign wrap        = wrap_q;
  assign mod_active  = mod_q;
  assign mod_pending = pending_q;
endmodule

// File: tb/tb_modn_prog_counter.sv
// tb_modn_prog_counter: directed plus random checks of modn_prog_counter against an arithmetic model.
module tb_modn_prog_counter;
  localparam int W = 4;
  localparam int DM = 10;
  logic clk = 1'b0, reset, en, up, load, mod_wr;
  logic [W-1:0] load_val, mod_in, count, mod_active;
  logic tc, wrap, mod_pending;
  int n_checks = 0, n_fail = 0;
  int cnt, ma, pend, pv, wr_exp;

  modn_prog_counter #(.WIDTH(W), .DEFAULT_MOD(DM)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .mod_wr(mod_wr), .mod_in(mod_in), .count(count), .tc(tc), .wrap(wrap),
    .mod_active(mod_active), .mod_pending(mod_pending));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mval(input int m);
    return (m == 0) ? (1 << W) : m;
  endfunction

  task automatic step();
    int m, m2, nma, tc_e, app;
    #1;
    m = mval(ma);
    tc_e = (en && !load && (up ? cnt == m - 1 : cnt == 0)) ? 1 : 0;
    chk("tc", int'(tc), tc_e);
    @(posedge clk);
    if (reset) begin
      cnt = 0; ma = DM; pend = 0; pv = 0; wr_exp = 0;
    end else begin
`ifdef MODN_SATURATE_EN
      app = (pend || mod_wr) && load;
`else
      app = (pend || mod_wr) && (load || tc_e);
`endif
      nma = app ? (mod_wr ? int'(mod_in) : pv) : ma;
      m2 = mval(nma);
      if (load) cnt = (int'(load_val) < m2 - 1) ? int'(load_val) : m2 - 1;
      else if (en) begin
`ifdef MODN_SATURATE_EN
        if (up) cnt = (cnt == m - 1) ? cnt : cnt + 1;
        else cnt = (cnt == 0) ? 0 : cnt - 1;
`else
        if (up) cnt = (cnt + 1) % m;
        else cnt = (cnt == 0) ? m2 - 1 : cnt - 1;
`endif
      end
`ifdef MODN_SATURATE_EN
      wr_exp = 0;
`else
      wr_exp = tc_e;
`endif
      pend = app ? 0 : ((mod_wr || pend) ? 1 : 0);
      if (mod_wr) pv = int'(mod_in);
      ma = nma;
    end
    #1;
    chk("count", int'(count), cnt);
    chk("wrap", int'(wrap), wr_exp);
    chk("mod_active", int'(mod_active), ma);
    chk("mod_pending", int'(mod_pending), pend);
  endtask

  initial begin
    reset = 1; en = 0; up = 1; load = 0; mod_wr = 0; load_val = '0; mod_in = '0;
    cnt = 0; ma = DM; pend = 0; pv = 0; wr_exp = 0;
    step(); step();
    reset = 0;
    chk("reset_count", int'(count), 0);
    chk("reset_mod", int'(mod_active), DM);
    // up run
    en = 1; up = 1;
    repeat (12) step();
`ifndef MODN_SATURATE_EN
    chk("up12_count", int'(count), 2);
`endif
    // down run from 0
    load = 1; load_val = 0; step(); load = 0; up = 0;
    repeat (12) step();
    // load clamp and priority over en
    up = 1; load = 1; load_val = 4'd12; step();
    chk("load_clamp", int'(count), 9);
    load_val = 4'd6; step();
    chk("load_6", int'(count), 6);
    // deferred modulus change at wrap
    load_val = 4'd3; step(); load = 0;
    mod_wr = 1; mod_in = 4'd5; step(); mod_wr = 0;
    repeat (14) step();
    // M = 16 and M = 1 applied via load
    load = 1; load_val = 0; mod_wr = 1; mod_in = 4'd0; step(); load = 0; mod_wr = 0;
    repeat (18) step();
    up = 0; repeat (3) step(); up = 1;
    load = 1; mod_wr = 1; mod_in = 4'd1; step(); load = 0; mod_wr = 0;
    repeat (4) step();
    up = 0; repeat (3) step();
    // reset with a pending modulus
    load = 1; load_val = 4'd7; mod_wr = 1; mod_in = 4'd10; step(); load = 0; mod_wr = 0;
    en = 0; mod_wr = 1; mod_in = 4'd3; step(); mod_wr = 0;
    reset = 1; step(); reset = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_mod", int'(mod_active), DM);
    chk("rst_pending", int'(mod_pending), 0);
    en = 1; up = 1; repeat (12) step();
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      en       = ($urandom_range(0, 9) < 8);
      up       = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 99) < 8);
      load_val = W'($urandom_range(0, 15));
      mod_wr   = ($urandom_range(0, 99) < 10);
      mod_in   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom_range(0, 15));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
